// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM delay-line controller.
// Imported by the controller top and its pointer sub-module.
package ram_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-2^N pointer: synchronous clear has priority over increment,
// and the increment wraps naturally at the top of the range.
module wrap_ptr #(
   parameter int unsigned N = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [N-1:0] ptr
);

   localparam logic [N-1:0] PTR_ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] ptr_q;
   logic [N-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + PTR_ONE;
      end else begin
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/ram_delay_ctrl.sv
// Runs a dual-port sample RAM as a programmable delay line: one write per
// accepted strobe, plus a read offset samples behind once the buffer is full.
module ram_delay_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH    = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     hold,
   input  logic                     sample_en,
   input  logic [ADDRESS_WIDTH-1:0] offset,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic                     ram_wen,
   output logic                     ram_ren,
   output logic [ADDRESS_WIDTH-1:0] ram_wad,
   output logic [ADDRESS_WIDTH-1:0] ram_rad,
   output logic [DATA_WIDTH-1:0]    ram_din,
   input  logic [DATA_WIDTH-1:0]    ram_dout,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   output logic                     busy,
   output logic                     filling
);

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   ctrl_state_t              state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
   logic [ADDRESS_WIDTH-1:0] off_q, off_d;
   logic                     dout_valid_q;
   logic                     busy_q;
   logic                     filling_q;

   logic [ADDRESS_WIDTH-1:0] wptr_s;
   logic [ADDRESS_WIDTH-1:0] fill_cnt_inc_s;
   logic                     active_s;
   logic                     accept_s;
   logic                     wptr_clr_s;

   // start/stop win over a strobe in the same cycle, so it is never accepted
   assign active_s       = (state_q == FILL) || (state_q == RUN);
   assign accept_s       = sample_en & ~hold & ~start & ~stop & active_s;
   assign fill_cnt_inc_s = fill_cnt_q + ADDR_ONE;
   assign wptr_clr_s     = start & ~stop;

   wrap_ptr #(
      .N (ADDRESS_WIDTH)
   ) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (wptr_clr_s),
      .inc   (accept_s),
      .ptr   (wptr_s)
   );

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      off_d      = off_q;
      if (stop) begin
         state_d = IDLE;
      end else if (start) begin
         state_d    = FILL;
         fill_cnt_d = '0;
         off_d      = (offset == '0) ? ADDR_ONE : offset;
      end else if (accept_s) begin
         case (state_q)
            FILL: begin
               fill_cnt_d = fill_cnt_inc_s;
               if (fill_cnt_inc_s == off_q) begin
                  state_d = RUN;
               end else begin
                  state_d = FILL;
               end
            end
            RUN:     state_d = RUN;
            default: state_d = state_q;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // off_q >= 1 keeps the read address distinct from the write address
   always_comb begin
      ram_wen = 1'b0;
      ram_wad = '0;
      ram_din = '0;
      ram_ren = 1'b0;
      ram_rad = '0;
      if (accept_s) begin
         ram_wen = 1'b1;
         ram_wad = wptr_s;
         ram_din = din;
         if (state_q == RUN) begin
            ram_ren = 1'b1;
            ram_rad = wptr_s - off_q;
         end else begin
            ram_ren = 1'b0;
            ram_rad = '0;
         end
      end else begin
         ram_wen = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fill_cnt_q   <= '0;
         off_q        <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         filling_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         off_q        <= off_d;
         dout_valid_q <= ram_ren;
         busy_q       <= (state_d != IDLE);
         filling_q    <= (state_d == FILL);
      end
   end

   assign dout       = ram_dout;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign filling    = filling_q;

endmodule

// File: tb/tb_ram_delay_ctrl.sv
// Bench for ram_delay_ctrl: a behavioural RAM, a sample-history model of
// the delay line checked every cycle, and directed literal expectations.
module tb_ram_delay_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start, stop, hold, sample_en;
   logic [8:0] offset;
   logic [7:0] din;
   logic       ram_wen, ram_ren;
   logic [8:0] ram_wad, ram_rad;
   logic [7:0] ram_din, ram_dout;
   logic [7:0] dout;
   logic       dout_valid, busy, filling;

   int checks = 0;
   int errors = 0;

   ram_delay_ctrl #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .hold       (hold),
      .sample_en  (sample_en),
      .offset     (offset),
      .din        (din),
      .ram_wen    (ram_wen),
      .ram_ren    (ram_ren),
      .ram_wad    (ram_wad),
      .ram_rad    (ram_rad),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .filling    (filling)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // registered-read sample RAM
   logic [7:0] mem [0:511];
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'd0;
      ram_dout = 8'd0;
   end
   always @(posedge clk) begin
      if (ram_wen) mem[ram_wad] <= ram_din;
      if (ram_ren) ram_dout <= mem[ram_rad];
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: history of accepted samples since start; strobe k reads sample k-off.
   logic       m_active;
   int         m_n;
   int         m_off;
   logic       m_exp_valid;
   logic [7:0] m_exp_dout;
   logic [7:0] hist[$];
   logic       m_acc, m_ren;

   assign m_acc = m_active && sample_en && !hold && !start && !stop;
   assign m_ren = m_acc && (m_n >= m_off);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active    <= 1'b0;
         m_n         <= 0;
         m_off       <= 0;
         m_exp_valid <= 1'b0;
         m_exp_dout  <= 8'd0;
         hist.delete();
      end else begin
         m_exp_valid <= m_ren;
         if (m_ren) m_exp_dout <= hist[m_n - m_off];
         if (stop) begin
            m_active <= 1'b0;
         end else if (start) begin
            m_active <= 1'b1;
            m_n      <= 0;
            m_off    <= (offset == 9'd0) ? 1 : int'(offset);
            hist.delete();
         end else if (m_acc) begin
            hist.push_back(din);
            m_n <= m_n + 1;
         end
      end
   end

   // compare DUT against the model every cycle, away from the active edge
   always @(negedge clk) begin
      chk("ram_wen", int'(ram_wen), int'(m_acc));
      chk("ram_wad", int'(ram_wad), m_acc ? (m_n % 512) : 0);
      chk("ram_din", int'(ram_din), m_acc ? int'(din) : 0);
      chk("ram_ren", int'(ram_ren), int'(m_ren));
      chk("ram_rad", int'(ram_rad), m_ren ? ((m_n - m_off) % 512) : 0);
      chk("dout_valid", int'(dout_valid), int'(m_exp_valid));
      if (m_exp_valid) chk("dout", int'(dout), int'(m_exp_dout));
      chk("busy", int'(busy), int'(m_active));
      chk("filling", int'(filling), int'(m_active && (m_n < m_off)));
   end

   task automatic drv(input logic st, input logic sp, input logic hd,
                      input logic se, input int off, input int d);
      @(posedge clk);
      #1;
      start     = st;
      stop      = sp;
      hold      = hd;
      sample_en = se;
      offset    = off[8:0];
      din       = d[7:0];
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
      sample_en = 1'b0; offset = 9'd0; din = 8'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);
      #2;
      chk("reset_busy", int'(busy), 0);
      chk("reset_valid", int'(dout_valid), 0);
      chk("reset_wen", int'(ram_wen), 0);

      // basic delay, offset 3
      drv(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
      for (int i = 0; i < 5; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 10 + i);
         #2;
         if (i < 3) chk("basic_no_read", int'(ram_ren), 0);
         if (i == 3) begin
            chk("basic_ren", int'(ram_ren), 1);
            chk("basic_rad0", int'(ram_rad), 0);
         end
         if (i == 4) begin
            chk("basic_rad1", int'(ram_rad), 1);
            chk("basic_dout10", int'(dout), 10);
            chk("basic_valid10", int'(dout_valid), 1);
         end
      end
      idle(1);
      #2;
      chk("basic_dout11", int'(dout), 11);
      chk("basic_valid11", int'(dout_valid), 1);
      idle(1);
      #2;
      chk("basic_valid_drop", int'(dout_valid), 0);

      // gaps
      drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 15);
      idle(3);
      drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 16);
      idle(1);
      drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 17);

      // hold with strobes present
      for (int i = 0; i < 5; i++) begin
         drv(1'b0, 1'b0, 1'b1, 1'b1, 0, 99);
         #2;
         chk("hold_wen", int'(ram_wen), 0);
         chk("hold_ren", int'(ram_ren), 0);
      end
      drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 18);
      idle(1);
      #2;
      chk("hold_lag_dout", int'(dout), 15);

      // stop, then strobes are ignored
      drv(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 50);
      #2;
      chk("stop_wen", int'(ram_wen), 0);
      chk("stop_busy", int'(busy), 0);

      // hold in IDLE has no effect
      drv(1'b0, 1'b0, 1'b1, 1'b1, 0, 51);

      // start and stop together -> IDLE
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4, 0);
      idle(1);
      #2;
      chk("startstop_busy", int'(busy), 0);

      // restart from RUN with offset 5
      drv(1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
      for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 20 + i);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
      for (int i = 0; i < 7; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 30 + i);
         #2;
         if (i < 5) begin
            chk("restart_no_read", int'(ram_ren), 0);
            chk("restart_filling", int'(filling), 1);
         end
         if (i == 5) begin
            chk("restart_ren", int'(ram_ren), 1);
            chk("restart_rad", int'(ram_rad), 0);
            chk("restart_run", int'(filling), 0);
         end
      end
      idle(2);

      // offset 0 behaves as 1
      drv(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 40 + i);
         #2;
         if (i == 0) chk("off0_first_no_read", int'(ram_ren), 0);
         if (i == 1) begin
            chk("off0_second_ren", int'(ram_ren), 1);
            chk("off0_second_rad", int'(ram_rad), 0);
         end
      end
      idle(2);

      // pointer wrap with offset 2
      drv(1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
      for (int i = 0; i < 515; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 0, i & 255);
         #2;
         if (i == 513) begin
            chk("wrap_wad", int'(ram_wad), 1);
            chk("wrap_rad", int'(ram_rad), 511);
            chk("wrap_lag_dout", int'(dout), 254);
         end
      end
      idle(2);

      // maximum offset 511
      drv(1'b1, 1'b0, 1'b0, 1'b0, 511, 0);
      for (int i = 0; i < 513; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 0, (i * 7 + 3) & 255);
         #2;
         if (i == 510) chk("max_no_read", int'(ram_ren), 0);
         if (i == 511) begin
            chk("max_ren", int'(ram_ren), 1);
            chk("max_rad", int'(ram_rad), 0);
         end
         if (i == 512) begin
            chk("max_valid", int'(dout_valid), 1);
            chk("max_dout", int'(dout), 3);
            chk("max_rad_oldest", int'(ram_rad), 1);
         end
      end

      // asynchronous reset in the middle of RUN
      @(posedge clk);
      #1;
      sample_en = 1'b1;
      din       = 8'd77;
      rst_n     = 1'b0;
      #1;
      chk("rst_wen", int'(ram_wen), 0);
      chk("rst_ren", int'(ram_ren), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(dout_valid), 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      sample_en = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 60);
      #2;
      chk("rst_needs_start", int'(ram_wen), 0);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 70 + i);
         #2;
         if (i < 3) chk("refill_no_valid", int'(dout_valid), 0);
         if (i == 3) chk("refill_dout", int'(dout), 70);
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_delay_ctrl.md
# ram_delay_ctrl

Sequencer that runs the dual-port sample RAM as a programmable delay line for the signal generator. It owns the RAM write and read ports, advances a circular write pointer once per sample strobe, and derives the read address as the write pointer minus a latched offset. It withholds reads until the buffer holds `offset` samples, then returns one delayed sample per strobe with a valid flag. It sits between the waveform source and the output path, with the RAM as its only datapath element.

## Interface
- `ADDRESS_WIDTH`, 9, RAM address width; buffer depth is 2^ADDRESS_WIDTH.
- `DATA_WIDTH`, 8, sample width.

- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle pulse; (re)starts the delay line.
- `stop`  in  1  single-cycle pulse; returns the block to IDLE.
- `hold`  in  1  level; freezes the pointers and suppresses RAM access.
- `sample_en`  in  1  sample strobe; each high cycle carries one sample.
- `offset`  in  ADDRESS_WIDTH  delay in samples; latched at `start`.
- `din`  in  DATA_WIDTH  input sample.
- `ram_wen`, `ram_ren`  out  1  RAM write and read enables.
- `ram_wad`, `ram_rad`  out  ADDRESS_WIDTH  RAM write and read addresses.
- `ram_din`  out  DATA_WIDTH  RAM write data.
- `ram_dout`  in  DATA_WIDTH  registered RAM read data, valid one cycle after `ram_ren`.
- `dout`  out  DATA_WIDTH  delayed sample; equals `ram_dout`.
- `dout_valid`  out  1  high exactly when `dout` carries a fresh read.
- `busy`  out  1  high in FILL or RUN.
- `filling`  out  1  high in FILL.

## Operation
- States:
  - IDLE: no RAM access.
  - FILL: writes only.
  - RUN: a write and a read per accepted strobe.
- Input priority: `stop` > `start` > `hold` > `sample_en`.
- `stop` in any state → IDLE. Pointers are left as they are.
- `start` in any state → FILL:
  - `wptr` and `fill_cnt` are cleared.
  - `offset` is latched into `off_q`; an `offset` of 0 is latched as 1.
  - `start` in FILL or RUN is a restart. Stale RAM contents are never read, because FILL gates the reads.
- Accepted strobe: `sample_en`=1, `hold`=0, state FILL or RUN, and no `start`/`stop` in that cycle.
- Every accepted strobe:
  - `ram_wen`=1, `ram_wad`=`wptr`, `ram_din`=`din`.
  - `wptr` increments modulo 2^ADDRESS_WIDTH, wrapping from 511 to 0.
- FILL, accepted strobe:
  - `fill_cnt` increments.
  - When the incremented value equals `off_q`, the next state is RUN.
- RUN, accepted strobe:
  - `ram_ren`=1, `ram_rad`=(`wptr` − `off_q`) mod 2^ADDRESS_WIDTH, computed in ADDRESS_WIDTH-bit unsigned wrap arithmetic.
  - The same-cycle write and read addresses always differ, because `off_q` ≥ 1.
- `ram_*` outputs are combinational from registered state plus `sample_en`/`hold`/`din`. They are 0 when no access occurs.
- `dout_valid` is a register loaded with `ram_ren`. `dout` is `ram_dout` passed straight through.
- The `offset` input is ignored except in a `start` cycle.
- `hold` in IDLE has no effect.

## Timing
- Reset values:
  - state IDLE.
  - `wptr`, `fill_cnt`, `off_q` = 0.
  - `dout_valid`, `busy`, `filling`, and all `ram_*` enables = 0.
- Reset mid-operation: immediate clear. RAM contents are not cleared. A `start` is required afterwards.
- The sample accepted at strobe k (0-indexed after `start`) is read at strobe k+`off_q`. It appears on `dout` with `dout_valid`=1 in the cycle after that strobe.
- `dout_valid` is high for exactly one cycle per RUN strobe. With back-to-back strobes it is high continuously.
- Strobe gaps of any length are allowed. A gap produces no write and no read.
- `busy` and `filling` are registered state decodes and change in the cycle after the transition edge.
- The FILL→RUN transition takes effect on the edge of the `off_q`-th strobe. The next strobe is the first read.
- `off_q`=511 with ADDRESS_WIDTH=9: the read address equals `wptr`+1, the oldest entry.

## Structure
- Package `ram_ctrl_pkg`:
  - `ctrl_state_t` enum {IDLE, FILL, RUN}.
  - Default width localparams.
- One sub-module, `wrap_ptr`: a modulo-2^N pointer with `clr`/`inc` inputs. It is instantiated for `wptr` only; `fill_cnt` is a plain counter.
- The RAM itself is instantiated outside this block.

## Test plan
- Reset: drive `rst_n` low mid-RUN → all outputs 0 in the same cycle, state IDLE. After `start`, the block refills before any `dout_valid`.
- Basic delay:
  - Stimulus: `offset`=3, `start`, strobes with `din`=10,11,12,13,14.
  - Response: no reads for the first 3 strobes. The 4th and 5th strobes give `ram_rad`=0,1, then `dout`=10,11 with `dout_valid`.
- Wrap: `offset`=2, 515 continuous strobes → `wptr` wraps 511→0. At `wptr`=1, `ram_rad`=511, and the data still lags by exactly 2 samples.
- Offset 0 and maximum:
  - `offset`=0 behaves as 1: the first read occurs on the 2nd strobe.
  - `offset`=511 gives the first `dout_valid` after the 512th strobe, with `dout` = the first sample.
- Hold and gaps: `hold`=1 for 5 cycles with `sample_en`=1 → no `ram_wen`/`ram_ren`, pointers unchanged, and the delay relationship is preserved afterwards.
- Priority:
  - `stop` and `start` in the same cycle → IDLE.
  - `start` in RUN with a new `offset`=5 → FILL; `fill_cnt` restarts and no read occurs for 5 strobes.
